// File: rtl/pdm_decoder.sv
// PDM to PCM decoder: 3rd-order CIC decimator (DECIM:1) with a valid/ready output register.
// Latency: sample valid 2 cycles after the edge accepting the last bit of a frame; first 2 samples discarded.
// Backpressure: unconsumed sample is overwritten by the next; PDM_DECODER_OVERRUN_EN enables the sticky overrun flag.
module pdm_decoder #(
    parameter int NBITS = 24,
    parameter int DECIM = 256
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    output logic [NBITS-1:0] pcm_out,
    output logic             pcm_valid,
    input  logic             pcm_ready,
    output logic             overrun
);

    localparam int LOG = $clog2(DECIM);
    localparam int W   = 3 * LOG + 1;

    typedef enum logic {WARMUP, RUN} state_t;

    logic [W-1:0]     integ1, integ2, integ3;
    logic [W-1:0]     dly1, dly2, dly3;
    logic [W-1:0]     c1, c2, c3;
    logic [LOG-1:0]   dcnt;
    logic             dec_evt;
    logic             comb_vld;
    logic [NBITS-1:0] comb_pcm;
    state_t           state;
    logic             warm_cnt;

    // Integrators and decimation counter advance only on accepted bits.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            integ1  <= '0;
            integ2  <= '0;
            integ3  <= '0;
            dcnt    <= '0;
            dec_evt <= 1'b0;
        end else begin
            dec_evt <= din_valid && (dcnt == {LOG{1'b1}});
            if (din_valid) begin
                integ1 <= integ1 + {{(W-1){1'b0}}, din};
                integ2 <= integ2 + integ1;
                integ3 <= integ3 + integ2;
                dcnt   <= dcnt + {{(LOG-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        c1 = integ3 - dly1;
        c2 = c1 - dly2;
        c3 = c2 - dly3;
    end

    // All three combs in one registered stage; the MSB flags a result at or above 2^(W-1).
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            dly1     <= '0;
            dly2     <= '0;
            dly3     <= '0;
            comb_vld <= 1'b0;
            comb_pcm <= '0;
        end else begin
            comb_vld <= dec_evt;
            if (dec_evt) begin
                dly1     <= integ3;
                dly2     <= c1;
                dly3     <= c2;
                comb_pcm <= c3[W-1] ? {NBITS{1'b1}} : c3[W-2 -: NBITS];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= WARMUP;
            warm_cnt  <= 1'b0;
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
        end else begin
            if (comb_vld && state == WARMUP) begin
                warm_cnt <= 1'b1;
                if (warm_cnt)
                    state <= RUN;
            end else if (comb_vld) begin
                pcm_out   <= comb_pcm;
                pcm_valid <= 1'b1;
            end else if (pcm_valid && pcm_ready) begin
                pcm_valid <= 1'b0;
            end
        end
    end

`ifdef PDM_DECODER_OVERRUN_EN
    logic overrun_q;

    // A load while the held sample is still unconsumed loses that sample.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            overrun_q <= 1'b0;
        else if (comb_vld && state == RUN && pcm_valid && !pcm_ready)
            overrun_q <= 1'b1;
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_pdm_decoder.sv
// Directed bench for pdm_decoder at DECIM=256, NBITS=24; bits offered every 4th cycle unless gapped.
module tb_pdm_decoder;

    logic        CLOCK_50;
    logic        reset;
    logic        din;
    logic        din_valid;
    logic [23:0] pcm_out;
    logic        pcm_valid;
    logic        pcm_ready;
    logic        overrun;

`ifdef PDM_DECODER_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int nbits  = 0;
    int acc_cyc = 0;
    logic prev_valid = 1'b0;

    int          ev_bits[$];
    int          ev_lat[$];
    logic [23:0] ev_val[$];

    pdm_decoder #(.NBITS(24), .DECIM(256)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .pcm_out   (pcm_out),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .overrun   (overrun)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // One clock; records accepted bits and every rising pcm_valid with its value and latency.
    task automatic tick();
        logic dv;
        dv = din_valid && !reset;
        @(posedge CLOCK_50);
        #1;
        cyc++;
        if (dv) begin
            nbits++;
            acc_cyc = cyc;
        end
        if (pcm_valid && !prev_valid) begin
            ev_bits.push_back(nbits);
            ev_lat.push_back(cyc - acc_cyc);
            ev_val.push_back(pcm_out);
        end
        prev_valid = pcm_valid;
    endtask

    task automatic clear_events();
        ev_bits.delete();
        ev_lat.delete();
        ev_val.delete();
        nbits = 0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        clear_events();
    endtask

    // mode 0: zeros, 1: ones, 2: 1010..., 3: 1110...; gap_max 0 means every 4th cycle.
    task automatic send_bits(input int n, input int mode, input int gap_max);
        int idle;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       din = 1'b0;
                1:       din = 1'b1;
                2:       din = (i % 2 == 0);
                default: din = (i % 4 != 3);
            endcase
            din_valid = 1'b1;
            tick();
            din_valid = 1'b0;
            idle = (gap_max == 0) ? 3 : int'($urandom_range(1, gap_max));
            repeat (idle) tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (pcm_out !== 24'h0) begin n_fail++; $display("FAIL reset_pcm_out: got %h expected 000000", pcm_out); end
        n_cmp++;
        if (pcm_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pcm_valid: got %b expected 0", pcm_valid); end
        n_cmp++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        reset = 1'b0;
    endtask

    task automatic test_all_ones();
        do_reset();
        send_bits(1024, 1, 0);
        n_cmp++;
        if (ev_val.size() != 2) begin n_fail++; $display("FAIL ones_count: got %0d expected 2", ev_val.size()); end
        if (ev_val.size() >= 1) begin
            n_cmp++;
            if (ev_bits[0] != 768) begin n_fail++; $display("FAIL ones_first_bits: got %0d expected 768", ev_bits[0]); end
            n_cmp++;
            if (ev_lat[0] != 2) begin n_fail++; $display("FAIL ones_latency: got %0d expected 2", ev_lat[0]); end
        end
        for (int k = 0; k < ev_val.size(); k++) begin
            n_cmp++;
            if (ev_val[k] !== 24'hFFFFFF) begin n_fail++; $display("FAIL ones_value[%0d]: got %h expected FFFFFF", k, ev_val[k]); end
        end
    endtask

    task automatic test_all_zeros();
        do_reset();
        send_bits(1024, 0, 0);
        n_cmp++;
        if (ev_val.size() != 2) begin n_fail++; $display("FAIL zeros_count: got %0d expected 2", ev_val.size()); end
        for (int k = 0; k < ev_val.size(); k++) begin
            n_cmp++;
            if (ev_val[k] !== 24'h000000) begin n_fail++; $display("FAIL zeros_value[%0d]: got %h expected 000000", k, ev_val[k]); end
        end
    endtask

    task automatic test_alternating();
        do_reset();
        send_bits(1280, 2, 0);
        n_cmp++;
        if (ev_val.size() != 3) begin n_fail++; $display("FAIL alt_count: got %0d expected 3", ev_val.size()); end
        for (int k = 0; k < ev_val.size(); k++) begin
            n_cmp++;
            if (ev_val[k] !== 24'h800000) begin n_fail++; $display("FAIL alt_value[%0d]: got %h expected 800000", k, ev_val[k]); end
        end
    endtask

    // Zeros then a step to ones: the sample after the step is C(256,3) = 0x2A2B00.
    task automatic test_overrun();
        do_reset();
        pcm_ready = 1'b0;
        send_bits(768, 0, 0);
        n_cmp++;
        if (!(ev_val.size() == 1 && ev_val[0] === 24'h0)) begin n_fail++; $display("FAIL ovr_first: got count %0d expected 1 sample of 000000", ev_val.size()); end
        send_bits(256, 1, 0);
        n_cmp++;
        if (pcm_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_held: got %b expected 1", pcm_valid); end
        n_cmp++;
        if (pcm_out !== 24'h2A2B00) begin n_fail++; $display("FAIL ovr_second_sample: got %h expected 2A2B00", pcm_out); end
        n_cmp++;
        if (overrun !== OVR_EXP) begin n_fail++; $display("FAIL ovr_flag: got %b expected %b", overrun, OVR_EXP); end
        pcm_ready = 1'b1;
        tick();
        n_cmp++;
        if (pcm_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_clear: got %b expected 0", pcm_valid); end
        n_cmp++;
        if (overrun !== OVR_EXP) begin n_fail++; $display("FAIL ovr_sticky: got %b expected %b", overrun, OVR_EXP); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        pcm_ready = 1'b0;
        send_bits(1124, 1, 0);
        n_cmp++;
        if (pcm_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b expected 1", pcm_valid); end
        reset = 1'b1;
        #2;
        n_cmp++;
        if (pcm_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", pcm_valid); end
        n_cmp++;
        if (pcm_out !== 24'h0) begin n_fail++; $display("FAIL midrst_pcm_out: got %h expected 000000", pcm_out); end
        n_cmp++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_overrun: got %b expected 0", overrun); end
        tick();
        reset = 1'b0;
        clear_events();
        pcm_ready = 1'b1;
        send_bits(768, 1, 0);
        n_cmp++;
        if (!(ev_val.size() == 1 && ev_bits[0] == 768 && ev_lat[0] == 2)) begin
            n_fail++;
            $display("FAIL midrst_restart: got %0d samples (first at bit %0d) expected 1 at bit 768 latency 2",
                     ev_val.size(), (ev_bits.size() > 0) ? ev_bits[0] : -1);
        end
        n_cmp++;
        if (!(ev_val.size() == 1 && ev_val[0] === 24'hFFFFFF)) begin n_fail++; $display("FAIL midrst_value: expected one sample of FFFFFF, got %0d samples", ev_val.size()); end
    endtask

    // Pattern 1110 has 192 ones per frame: 192 * 2^16 = 0xC00000, with or without gaps.
    task automatic test_gaps(input int gap_max);
        do_reset();
        send_bits(1024, 3, gap_max);
        n_cmp++;
        if (ev_val.size() != 2) begin n_fail++; $display("FAIL gaps%0d_count: got %0d expected 2", gap_max, ev_val.size()); end
        for (int k = 0; k < ev_val.size(); k++) begin
            n_cmp++;
            if (ev_val[k] !== 24'hC00000) begin n_fail++; $display("FAIL gaps%0d_value[%0d]: got %h expected C00000", gap_max, k, ev_val[k]); end
            n_cmp++;
            if (ev_bits[k] != 768 + 256 * k) begin n_fail++; $display("FAIL gaps%0d_bits[%0d]: got %0d expected %0d", gap_max, k, ev_bits[k], 768 + 256 * k); end
        end
    endtask

    initial begin
        reset     = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        pcm_ready = 1'b1;
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_alternating();
        test_overrun();
        test_mid_reset();
        test_gaps(0);
        test_gaps(50);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pdm_decoder.md
PDM_DECODER -- requirements
Module: pdm_decoder

Interface
REQ-001 SHALL have parameter NBITS, default 24: width of the PCM output, matching AMPLITUDE_BITS.
REQ-002 SHALL have parameter DECIM, default 256: decimation ratio, a power of two with 3*log2(DECIM) >= NBITS.
REQ-003 SHALL have port CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high.
REQ-005 SHALL have port din  input  1  PDM bitstream; 1 = +full scale, 0 = zero.
REQ-006 SHALL have port din_valid  input  1  strobe; din is accepted on each cycle it is high.
REQ-007 SHALL have port pcm_out  output  NBITS  unsigned decoded sample.
REQ-008 SHALL have port pcm_valid  output  1  sample-available flag.
REQ-009 SHALL have port pcm_ready  input  1  consumer accepts the sample when it is high while pcm_valid is high.
REQ-010 SHALL have port overrun  output  1  sticky flag: an unconsumed sample was overwritten.

Function
REQ-011 SHALL implement a 3rd-order CIC decimator with internal width W = 3*log2(DECIM)+1 and modulo-2^W wrap-around arithmetic.
REQ-012 SHALL update the three integrators only on cycles where din_valid=1; when din_valid=0 the integrators hold.
REQ-013 SHALL count accepted bits in a log2(DECIM)-bit counter that wraps to 0 on the DECIM-th accepted bit; this wrap is the decimation event.
REQ-014 SHALL, on each decimation event, run three comb stages (differential delay 1) on the decimated integrator value in a single registered stage.
REQ-015 SHALL saturate the comb result to 2^(W-1)-1 and present bits [W-2 : W-1-NBITS] as the sample.
REQ-016 SHALL assert pcm_valid, with pcm_out updated, exactly 2 CLOCK_50 cycles after the edge that accepts the DECIM-th bit of a frame.
REQ-017 SHALL hold pcm_valid high and pcm_out stable until pcm_ready=1 is sampled; pcm_valid then clears on the next edge unless a new sample loads on that same edge.
REQ-018 SHALL use an FSM with states WARMUP and RUN; reset enters WARMUP.
REQ-019 SHALL, in WARMUP, discard the first 2 decimated samples with pcm_valid staying 0, then move to RUN; only samples produced in RUN are presented.
REQ-020 SHALL, when a new sample arrives while pcm_valid=1 and pcm_ready=0, overwrite pcm_out and keep pcm_valid=1.
REQ-021 SHALL, when a new sample arrives on the same edge pcm_ready=1 is sampled, load the new sample, keep pcm_valid=1, and treat it as no overwrite.

Reset
REQ-022 SHALL, while reset is high, clear the integrators, comb delays, decimation counter, pcm_out (0), pcm_valid (0) and overrun (0), and put the FSM in WARMUP.
REQ-023 SHALL, on reset asserted mid-frame or mid-handshake, abort immediately and drop any pending sample; after release it restarts the warm-up.

Configuration
REQ-024 SHALL, with macro PDM_DECODER_OVERRUN_EN defined, set overrun to 1 on any overwrite per REQ-020 and hold it until reset.
REQ-025 SHALL, without PDM_DECODER_OVERRUN_EN, keep the overrun port present but drive it constantly 0, with no change to any other behaviour.

Verification (DECIM=256, NBITS=24, din_valid high every 4th cycle, pcm_ready tied 1 unless stated)
REQ-026 SHALL cover: all-ones din -> first pcm_valid after 768 accepted bits; pcm_out=24'hFFFFFF (saturated from 2^24); the DECIM-th bit edge to pcm_valid is exactly 2 cycles.
REQ-027 SHALL cover: all-zeros din -> every presented sample = 24'h000000.
REQ-028 SHALL cover: alternating 1,0,1,0 din -> every presented sample = 24'h800000 exactly.
REQ-029 SHALL cover: pcm_ready=0 across two decimation events -> pcm_valid stays 1, pcm_out = second sample, overrun=1 with the macro and 0 without it; pcm_ready=1 then clears pcm_valid one cycle later.
REQ-030 SHALL cover: reset pulsed mid-frame after 100 accepted bits -> all outputs 0 at once; the next pcm_valid follows a further 768 accepted bits.
REQ-031 SHALL cover: din_valid gaps of 1-50 cycles with a fixed pattern -> pcm_out identical to the gap-free run; the integrators hold during gaps.
